// File: rtl/control_unit_pkg.sv
// Shared types and constants for the triangular-number processor.
// Holds the FSM state encoding, the ALU operation codes and the register indices.
package control_unit_pkg;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 3;

  typedef enum logic [3:0] {
    IDLE  = 4'd0,
    INIT1 = 4'd1,
    INIT2 = 4'd2,
    INIT3 = 4'd3,
    K2    = 4'd4,
    K4    = 4'd5,
    K8    = 4'd6,
    K10   = 4'd7,
    CMP   = 4'd8,
    INC   = 4'd9,
    ACC   = 4'd10,
    OUT   = 4'd11,
    DONE  = 4'd12
  } state_t;

  typedef enum logic [1:0] {
    ALU_ADD = 2'd0,
    ALU_SUB = 2'd1,
    ALU_AND = 2'd2,
    ALU_OR  = 2'd3
  } alu_op_t;

  localparam logic [ADDR_W-1:0] R0 = 3'd0;
  localparam logic [ADDR_W-1:0] R1 = 3'd1;
  localparam logic [ADDR_W-1:0] R2 = 3'd2;
  localparam logic [ADDR_W-1:0] R3 = 3'd3;
  localparam logic [ADDR_W-1:0] R4 = 3'd4;
  localparam logic [ADDR_W-1:0] R5 = 3'd5;

  // 8-bit wrapping ALU shared by the datapath.
  function automatic logic [DATA_W-1:0] alu_eval(input alu_op_t op,
                                                 input logic [DATA_W-1:0] a,
                                                 input logic [DATA_W-1:0] b);
    logic [DATA_W-1:0] r;
    case (op)
      ALU_ADD: r = a + b;
      ALU_SUB: r = a - b;
      ALU_AND: r = a & b;
      ALU_OR:  r = a | b;
      default: r = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/control_unit_datapath.sv
// Register file (R0 reads zero), ALU, write-source mux and output register.
// Driven entirely by control_unit; reports RData1 < RData2 back as lte.
module control_unit_datapath
  import control_unit_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              RFSrcMuxSel,
  input  logic [ADDR_W-1:0] RAddr1,
  input  logic [ADDR_W-1:0] RAddr2,
  input  logic [ADDR_W-1:0] WAddr,
  input  logic              we,
  input  logic              OutPortEn,
  input  logic [1:0]        ALUop,
  output logic              lte,
  output logic [DATA_W-1:0] OutPort
);

  logic [DATA_W-1:0] regs [0:7];
  logic [DATA_W-1:0] rdata1;
  logic [DATA_W-1:0] rdata2;
  logic [DATA_W-1:0] alu_res;
  logic [DATA_W-1:0] wdata;

  assign rdata1  = (RAddr1 == R0) ? '0 : regs[RAddr1];
  assign rdata2  = (RAddr2 == R0) ? '0 : regs[RAddr2];
  assign alu_res = alu_eval(alu_op_t'(ALUop), rdata1, rdata2);
  assign wdata   = RFSrcMuxSel ? DATA_W'(1) : alu_res;
  assign lte     = (rdata1 < rdata2);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 8; i++) regs[i] <= '0;
    end else if (we && (WAddr != R0)) begin
      regs[WAddr] <= wdata;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) OutPort <= '0;
    else if (OutPortEn) OutPort <= rdata1;
  end

endmodule

// File: rtl/dedicated_processor.sv
// Processor top: the control_unit sequencer wired to its datapath.
module dedicated_processor
  import control_unit_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] OutPort
);

  logic              rf_src_sel;
  logic [ADDR_W-1:0] raddr1;
  logic [ADDR_W-1:0] raddr2;
  logic [ADDR_W-1:0] waddr;
  logic              wr_en;
  logic              out_en;
  logic [1:0]        alu_op;
  logic              lte;

  control_unit u_ctrl (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .lte         (lte),
    .RFSrcMuxSel (rf_src_sel),
    .RAddr1      (raddr1),
    .RAddr2      (raddr2),
    .WAddr       (waddr),
    .we          (wr_en),
    .OutPortEn   (out_en),
    .ALUop       (alu_op),
    .busy        (busy),
    .done        (done)
  );

  control_unit_datapath u_dp (
    .clk         (clk),
    .reset       (reset),
    .RFSrcMuxSel (rf_src_sel),
    .RAddr1      (raddr1),
    .RAddr2      (raddr2),
    .WAddr       (waddr),
    .we          (wr_en),
    .OutPortEn   (out_en),
    .ALUop       (alu_op),
    .lte         (lte),
    .OutPort     (OutPort)
  );

endmodule

// File: rtl/control_unit.sv
// Moore sequencer that drives the datapath through the 1..55 triangular-number program.
// Outputs decode from the current state only; anything not set in a state stays 0.
//
//   state | meaning
//   IDLE  | waiting for start, all outputs 0
//   INIT1 | R1 = 1
//   INIT2 | R2 = 0
//   INIT3 | R3 = 0
//   K2    | R4 = R1 + R1
//   K4    | R5 = R4 + R4
//   K8    | R5 = R5 + R5
//   K10   | R4 = R5 + R4 (loop limit 10)
//   CMP   | test R3 < R4
//   INC   | R3 = R3 + R1
//   ACC   | R2 = R2 + R3
//   OUT   | OutPort <= R2
//   DONE  | one-cycle done pulse
module control_unit
  import control_unit_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              lte,
  output logic              RFSrcMuxSel,
  output logic [ADDR_W-1:0] RAddr1,
  output logic [ADDR_W-1:0] RAddr2,
  output logic [ADDR_W-1:0] WAddr,
  output logic              we,
  output logic              OutPortEn,
  output logic [1:0]        ALUop,
  output logic              busy,
  output logic              done
);

  state_t state, state_nx;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx    = IDLE;
    RFSrcMuxSel = 1'b0;
    RAddr1      = R0;
    RAddr2      = R0;
    WAddr       = R0;
    we          = 1'b0;
    OutPortEn   = 1'b0;
    ALUop       = ALU_ADD;
    busy        = 1'b1;
    done        = 1'b0;
    case (state)
      IDLE: begin
        busy     = 1'b0;
        state_nx = start ? INIT1 : IDLE;
      end
      INIT1: begin
        RFSrcMuxSel = 1'b1;
        WAddr       = R1;
        we          = 1'b1;
        state_nx    = INIT2;
      end
      INIT2: begin
        WAddr    = R2;
        we       = 1'b1;
        state_nx = INIT3;
      end
      INIT3: begin
        WAddr    = R3;
        we       = 1'b1;
        state_nx = K2;
      end
      K2: begin
        RAddr1   = R1;
        RAddr2   = R1;
        WAddr    = R4;
        we       = 1'b1;
        state_nx = K4;
      end
      K4: begin
        RAddr1   = R4;
        RAddr2   = R4;
        WAddr    = R5;
        we       = 1'b1;
        state_nx = K8;
      end
      K8: begin
        RAddr1   = R5;
        RAddr2   = R5;
        WAddr    = R5;
        we       = 1'b1;
        state_nx = K10;
      end
      K10: begin
        RAddr1   = R5;
        RAddr2   = R4;
        WAddr    = R4;
        we       = 1'b1;
        state_nx = CMP;
      end
      CMP: begin
        RAddr1   = R3;
        RAddr2   = R4;
        state_nx = lte ? INC : DONE;
      end
      INC: begin
        RAddr1   = R3;
        RAddr2   = R1;
        WAddr    = R3;
        we       = 1'b1;
        state_nx = ACC;
      end
      ACC: begin
        RAddr1   = R2;
        RAddr2   = R3;
        WAddr    = R2;
        we       = 1'b1;
        state_nx = OUT;
      end
      OUT: begin
        RAddr1    = R2;
        OutPortEn = 1'b1;
        state_nx  = CMP;
      end
      DONE: begin
        done     = 1'b1;
        state_nx = IDLE;
      end
      // Unused encodings fall back to IDLE with all outputs quiet.
      default: begin
        busy     = 1'b0;
        state_nx = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit, with a behavioural register file closing the lte loop
// and a dedicated_processor instance running the same program alongside.
module tb_control_unit;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic start = 1'b0;
  logic force_lte0 = 1'b0;
  logic lte;

  logic       RFSrcMuxSel;
  logic [2:0] RAddr1;
  logic [2:0] RAddr2;
  logic [2:0] WAddr;
  logic       we;
  logic       OutPortEn;
  logic [1:0] ALUop;
  logic       busy;
  logic       done;

  logic       dp_busy;
  logic       dp_done;
  logic [7:0] dp_out;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  control_unit dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .lte         (lte),
    .RFSrcMuxSel (RFSrcMuxSel),
    .RAddr1      (RAddr1),
    .RAddr2      (RAddr2),
    .WAddr       (WAddr),
    .we          (we),
    .OutPortEn   (OutPortEn),
    .ALUop       (ALUop),
    .busy        (busy),
    .done        (done)
  );

  dedicated_processor dp (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .busy    (dp_busy),
    .done    (dp_done),
    .OutPort (dp_out)
  );

  // Behavioural register file fed by the standalone control_unit.
  logic [7:0] m_regs [0:7];
  logic [7:0] m_rd1, m_rd2, m_alu;

  always_comb begin
    m_rd1 = (RAddr1 == 3'd0) ? 8'd0 : m_regs[RAddr1];
    m_rd2 = (RAddr2 == 3'd0) ? 8'd0 : m_regs[RAddr2];
    case (ALUop)
      2'd0:    m_alu = m_rd1 + m_rd2;
      2'd1:    m_alu = m_rd1 - m_rd2;
      2'd2:    m_alu = m_rd1 & m_rd2;
      default: m_alu = m_rd1 | m_rd2;
    endcase
  end

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 8; i++) m_regs[i] <= 8'd0;
    end else if (we && WAddr != 3'd0) begin
      m_regs[WAddr] <= RFSrcMuxSel ? 8'd1 : m_alu;
    end
  end

  assign lte = force_lte0 ? 1'b0 : (m_rd1 < m_rd2);

  logic [15:0] obs;
  assign obs = {RFSrcMuxSel, RAddr1, RAddr2, WAddr, we, OutPortEn, ALUop, busy, done};

  function automatic logic [15:0] mk(input int mux, input int ra1, input int ra2, input int wa,
                                     input int w, input int oe, input int op, input int b,
                                     input int d);
    return {1'(mux), 3'(ra1), 3'(ra2), 3'(wa), 1'(w), 1'(oe), 2'(op), 1'(b), 1'(d)};
  endfunction

  // Expected outputs k cycles after the edge that samples start (k=0 is INIT1).
  function automatic logic [15:0] exp_vec(input int k);
    logic [15:0] v;
    v = 16'h0000;
    if (k == 0)      v = mk(1, 0, 0, 1, 1, 0, 0, 1, 0);
    else if (k == 1) v = mk(0, 0, 0, 2, 1, 0, 0, 1, 0);
    else if (k == 2) v = mk(0, 0, 0, 3, 1, 0, 0, 1, 0);
    else if (k == 3) v = mk(0, 1, 1, 4, 1, 0, 0, 1, 0);
    else if (k == 4) v = mk(0, 4, 4, 5, 1, 0, 0, 1, 0);
    else if (k == 5) v = mk(0, 5, 5, 5, 1, 0, 0, 1, 0);
    else if (k == 6) v = mk(0, 5, 4, 4, 1, 0, 0, 1, 0);
    else if (k >= 7 && k <= 47) begin
      case ((k - 7) % 4)
        0:       v = mk(0, 3, 4, 0, 0, 0, 0, 1, 0);
        1:       v = mk(0, 3, 1, 3, 1, 0, 0, 1, 0);
        2:       v = mk(0, 2, 3, 2, 1, 0, 0, 1, 0);
        default: v = mk(0, 2, 0, 0, 0, 1, 0, 1, 0);
      endcase
    end else if (k == 48) v = mk(0, 0, 0, 0, 0, 0, 0, 1, 1);
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    start = 1'b0;
    force_lte0 = 1'b0;
    repeat (3) tick();
    reset = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    do_reset();
    for (int c = 0; c < 20; c++) begin
      checks++;
      if ({obs, dp_out, dp_busy, dp_done} !== 26'd0) begin
        errors++;
        $display("FAIL reset_idle c=%0d got outs=%h out_port=%0d busy=%b done=%b required all 0",
                 c, obs, dp_out, dp_busy, dp_done);
      end
      tick();
    end
  endtask

  task automatic test_run();
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k <= 48; k++) begin
      checks++;
      if (obs !== exp_vec(k)) begin
        errors++;
        $display("FAIL run_trace k=%0d got %h required %h", k, obs, exp_vec(k));
      end
      checks++;
      if ({dp_busy, dp_done} !== {1'b1, k == 48}) begin
        errors++;
        $display("FAIL run_status k=%0d got busy=%b done=%b required busy=1 done=%b",
                 k, dp_busy, dp_done, k == 48);
      end
      if (k >= 11 && (k - 11) % 4 == 0) begin
        checks++;
        if (dp_out !== 8'(((k - 11) / 4 + 1) * ((k - 11) / 4 + 2) / 2)) begin
          errors++;
          $display("FAIL run_outport k=%0d got %0d required %0d", k, dp_out,
                   ((k - 11) / 4 + 1) * ((k - 11) / 4 + 2) / 2);
        end
      end
      tick();
    end
    checks++;
    if ({obs, dp_out, dp_busy} !== {16'h0000, 8'd55, 1'b0}) begin
      errors++;
      $display("FAIL run_end got outs=%h out_port=%0d busy=%b required outs=0000 out_port=55 busy=0",
               obs, dp_out, dp_busy);
    end
  endtask

  task automatic test_toggle();
    start = 1'b1;
    tick();
    for (int k = 0; k <= 48; k++) begin
      checks++;
      if (obs !== exp_vec(k) || dp_done !== (k == 48)) begin
        errors++;
        $display("FAIL toggle_trace k=%0d got %h done=%b required %h done=%b",
                 k, obs, dp_done, exp_vec(k), k == 48);
      end
      if (k >= 11 && (k - 11) % 4 == 0) begin
        checks++;
        if (dp_out !== 8'(((k - 11) / 4 + 1) * ((k - 11) / 4 + 2) / 2)) begin
          errors++;
          $display("FAIL toggle_outport k=%0d got %0d required %0d", k, dp_out,
                   ((k - 11) / 4 + 1) * ((k - 11) / 4 + 2) / 2);
        end
      end
      start = (k < 48) ? ((k % 2) == 0) : 1'b0;
      tick();
    end
    checks++;
    if ({obs, dp_out, dp_busy} !== {16'h0000, 8'd55, 1'b0}) begin
      errors++;
      $display("FAIL toggle_end got outs=%h out_port=%0d busy=%b required outs=0000 out_port=55 busy=0",
               obs, dp_out, dp_busy);
    end
  endtask

  task automatic test_lte0();
    force_lte0 = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k <= 8; k++) begin
      checks++;
      if (obs !== exp_vec(k <= 7 ? k : 48)) begin
        errors++;
        $display("FAIL lte0_trace k=%0d got %h required %h", k, obs, exp_vec(k <= 7 ? k : 48));
      end
      tick();
    end
    checks++;
    if (obs !== 16'h0000) begin
      errors++;
      $display("FAIL lte0_idle got %h required 0000", obs);
    end
    do_reset();
  endtask

  task automatic test_reset_midrun();
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (25) tick();
    checks++;
    if (obs !== exp_vec(25)) begin
      errors++;
      $display("FAIL midrun_pre got %h required %h", obs, exp_vec(25));
    end
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if ({obs, dp_out, dp_busy, dp_done} !== 26'd0) begin
      errors++;
      $display("FAIL midrun_async got outs=%h out_port=%0d busy=%b done=%b required all 0",
               obs, dp_out, dp_busy, dp_done);
    end
    tick();
    tick();
    reset = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick();
      checks++;
      if ({obs, dp_busy} !== 17'd0) begin
        errors++;
        $display("FAIL midrun_no_resume c=%0d got outs=%h busy=%b required 0", c, obs, dp_busy);
      end
    end
    test_run();
  endtask

  task automatic test_back_to_back();
    start = 1'b1;
    tick();
    for (int k = 0; k <= 98; k++) begin
      checks++;
      if (obs !== exp_vec(k % 50) ||
          {dp_busy, dp_done} !== {(k % 50) != 49, (k % 50) == 48}) begin
        errors++;
        $display("FAIL b2b_trace k=%0d got %h busy=%b done=%b required %h busy=%b done=%b",
                 k, obs, dp_busy, dp_done, exp_vec(k % 50), (k % 50) != 49, (k % 50) == 48);
      end
      if ((k % 50) == 48) begin
        checks++;
        if (dp_out !== 8'd55) begin
          errors++;
          $display("FAIL b2b_outport k=%0d got %0d required 55", k, dp_out);
        end
      end
      if (k == 98) start = 1'b0;
      tick();
    end
    tick();
    checks++;
    if ({obs, dp_busy} !== 17'd0) begin
      errors++;
      $display("FAIL b2b_stop got outs=%h busy=%b required 0", obs, dp_busy);
    end
  endtask

  initial begin
    test_reset();
    test_run();
    test_toggle();
    test_lte0();
    test_reset_midrun();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
